sha3_axis_absorber: RTL

SHA3_AXIS_ABSORBER -- requirements
Module: sha3_axis_absorber

---
 rtl/sha3_axis_absorber.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sha3_axis_absorber.sv
// ---------------------------------------------------------------------------
// sha3_axis_absorber
//
// Purpose:
//   Collects AXI-Stream message bytes into one SHA-3 rate block, applies the
//   SHA-3 multi-rate padding (0x06 ... 0x80), and hands each complete block
//   to the permutation side through a valid/ready handshake. The mode picks
//   the rate: 144/136/104/72 bytes for SHA3-224/256/384/512.
//
// Ports:
//   ACLK, ARESET     single clock, synchronous active-high reset
//   s_tdata          message beat, little-endian (byte k at [8k+7:8k])
//   s_tkeep          byte enables for s_tdata
//   s_tuser          mode, sampled on the first beat of each message
//   s_tvalid/s_tlast/s_tready   AXI-Stream slave handshake
//   block_o          padded rate block; bytes at or above the rate are zero
//   blk_valid/blk_ready         block handshake
//   blk_last         block is the final block of the message
//   blk_mode         mode of the message this block belongs to
//   keep_err         sticky flag for illegal s_tkeep patterns
// ---------------------------------------------------------------------------
module sha3_axis_absorber #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_RATE   = 1152
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [1:0]              s_tuser,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [MAX_RATE-1:0]     block_o,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic                    blk_last,
    output logic [1:0]              blk_mode,
    output logic                    keep_err
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT   = 2'd1,
        PADBLK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [MAX_RATE-1:0]   buf_q, buf_d;
    logic [7:0]            ptr_q, ptr_d;
    logic [1:0]            mode_q, mode_d;
    logic                  modeHeld_q, modeHeld_d;
    logic                  last_q, last_d;
    logic                  padPend_q, padPend_d;
    logic                  keepErr_q, keepErr_d;

    logic [1:0]            effMode;
    int                    beatRate;
    int                    padRate;
    int                    keepCnt;
    int                    newPtr;
    int                    wrIdx;
    logic [DATA_BYTES:0]   keepPlusOne;
    logic                  keepBad;

    // Rate in bytes for each SHA-3 mode.
    function automatic int rateOf(input logic [1:0] m);
        case (m)
            2'd0:    rateOf = 144;
            2'd1:    rateOf = 136;
            2'd2:    rateOf = 104;
            default: rateOf = 72;
        endcase
    endfunction

    // Beat-level helpers: the mode used for the current beat is the latched
    // one once a message has started, otherwise the incoming s_tuser. The
    // keep checks flag a partial non-last beat, or a last beat whose enables
    // are empty or not a run of ones starting at bit 0.
    always_comb begin
        effMode     = modeHeld_q ? mode_q : s_tuser;
        beatRate    = rateOf(effMode);
        padRate     = rateOf(mode_q);
        keepCnt     = 0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if (s_tkeep[j]) keepCnt = keepCnt + 1;
        end
        newPtr      = int'(ptr_q) + keepCnt;
        if (newPtr > beatRate) newPtr = beatRate;
        keepPlusOne = {1'b0, s_tkeep} + {{DATA_BYTES{1'b0}}, 1'b1};
        if (s_tlast) begin
            keepBad = (s_tkeep == '0) ||
                      ((s_tkeep & keepPlusOne[DATA_BYTES-1:0]) != '0);
        end else begin
            keepBad = !(&s_tkeep);
        end
    end

    // Next-state logic. FILL packs kept bytes at the pointer and, on a last
    // beat, pads in the same cycle so the block is ready one cycle later.
    // A last beat that exactly fills the rate leaves no room for padding, so
    // a pad-only block is built in PADBLK after the data block is taken.
    // The buffer above the pointer is always zero (cleared on every block
    // handshake), so padding only has to place the two marker bytes.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        modeHeld_d = modeHeld_q;
        last_d     = last_q;
        padPend_d  = padPend_q;
        keepErr_d  = keepErr_q;
        wrIdx      = 0;

        case (state_q)
            FILL: begin
                if (s_tvalid) begin
                    if (!modeHeld_q) begin
                        mode_d     = s_tuser;
                        modeHeld_d = 1'b1;
                    end
                    if (keepBad) keepErr_d = 1'b1;

                    wrIdx = int'(ptr_q);
                    for (int j = 0; j < DATA_BYTES; j++) begin
                        if (s_tkeep[j]) begin
                            if (wrIdx < beatRate) begin
                                buf_d[wrIdx*8 +: 8] = s_tdata[j*8 +: 8];
                            end
                            wrIdx = wrIdx + 1;
                        end
                    end
                    ptr_d = 8'(newPtr);

                    if (s_tlast) begin
                        state_d = EMIT;
                        if (newPtr < beatRate) begin
                            buf_d[newPtr*8 +: 8]         = 8'h06;
                            buf_d[(beatRate-1)*8 +: 8]   =
                                buf_d[(beatRate-1)*8 +: 8] | 8'h80;
                            last_d    = 1'b1;
                            padPend_d = 1'b0;
                        end else begin
                            last_d    = 1'b0;
                            padPend_d = 1'b1;
                        end
                    end else if (newPtr >= beatRate) begin
                        state_d   = EMIT;
                        last_d    = 1'b0;
                        padPend_d = 1'b0;
                    end
                end
            end

            EMIT: begin
                if (blk_ready) begin
                    buf_d     = '0;
                    ptr_d     = '0;
                    last_d    = 1'b0;
                    padPend_d = 1'b0;
                    if (last_q) modeHeld_d = 1'b0;
                    state_d   = padPend_q ? PADBLK : FILL;
                end
            end

            PADBLK: begin
                buf_d                      = '0;
                buf_d[7:0]                 = 8'h06;
                buf_d[(padRate-1)*8 +: 8]  = buf_d[(padRate-1)*8 +: 8] | 8'h80;
                last_d                     = 1'b1;
                state_d                    = EMIT;
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and datapath registers. Reset discards any partial block and
    // the mode latch; keep_err is only ever cleared here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= FILL;
            buf_q      <= '0;
            ptr_q      <= '0;
            mode_q     <= '0;
            modeHeld_q <= 1'b0;
            last_q     <= 1'b0;
            padPend_q  <= 1'b0;
            keepErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            modeHeld_q <= modeHeld_d;
            last_q     <= last_d;
            padPend_q  <= padPend_d;
            keepErr_q  <= keepErr_d;
        end
    end

    // Outputs come straight from registers, so they are stable while a
    // block waits for blk_ready.
    assign s_tready  = (state_q == FILL);
    assign blk_valid = (state_q == EMIT);
    assign block_o   = buf_q;
    assign blk_last  = last_q;
    assign blk_mode  = mode_q;
    assign keep_err  = keepErr_q;

endmodule
